// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants, selector codes and state encoding for the radix-8 Booth recoder
package booth_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_GROUPS = (DATA_WIDTH + 3) / 3;
  localparam int SREG_W     = 3 * NUM_GROUPS + 1;
  localparam int GRP_W      = $clog2(NUM_GROUPS);

  localparam logic [3:0] SEL_ZERO_P = 4'b0000;
  localparam logic [3:0] SEL_P4X    = 4'b0111;
  localparam logic [3:0] SEL_N4X    = 4'b1000;
  localparam logic [3:0] SEL_ZERO_N = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/booth_encode_seq_if.sv
// rtl/booth_encode_seq_if.sv - operand/selector handshake bundle between the Mul sequencer and the Booth recoder
interface booth_encode_seq_if;
  import booth_pkg::*;

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] b;
  logic                  is_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            sel;
  logic [GRP_W-1:0]      grp_idx;
  logic                  last;
  logic                  busy;

  modport master (
    output flush, in_valid, b, is_signed, out_ready,
    input  in_ready, out_valid, sel, grp_idx, last, busy
  );

  modport slave (
    input  flush, in_valid, b, is_signed, out_ready,
    output in_ready, out_valid, sel, grp_idx, last, busy
  );

endinterface

// File: rtl/booth_encode_seq.sv
// rtl/booth_encode_seq.sv - sequential radix-8 Booth recoder, one 4-bit window per beat
// Optional BOOTH_SKIP_ZERO_EN: zero windows (except the top group) are stepped over without a beat.
module booth_encode_seq
  import booth_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  booth_encode_seq_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [SREG_W-1:0]  sreg;
  logic [GRP_W-1:0]   grp_idx;
  logic               accept;
  logic               last_grp;
  logic               skip;
  logic               beat;
  logic               advance;
  logic               out_valid;
  logic               in_ready;
  logic               busy;
  logic               last;
  logic [3:0]         sel;

  assign last_grp = (grp_idx == GRP_W'(NUM_GROUPS - 1));
  assign accept   = (state == ST_IDLE) & bus.in_valid & ~bus.flush;

`ifdef BOOTH_SKIP_ZERO_EN
  logic zero_win;
  assign zero_win = (sreg[3:0] == SEL_ZERO_P) | (sreg[3:0] == SEL_ZERO_N);
  // The top group always goes out so the consumer always sees a last beat.
  assign skip     = (state == ST_RUN) & zero_win & ~last_grp;
`else
  assign skip     = 1'b0;
`endif

  assign beat    = out_valid & bus.out_ready;
  assign advance = beat | skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush)                state_nxt = ST_IDLE;
        else if (advance && last_grp) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    sel       = 4'b0000;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_RUN: begin
        busy      = 1'b1;
        out_valid = ~skip;
        sel       = sreg[3:0];
        last      = last_grp;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Extension bits are loaded up front, so a logical shift is enough per group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      grp_idx <= '0;
    end else if (accept) begin
      sreg    <= {{(SREG_W - DATA_WIDTH - 1){bus.is_signed & bus.b[DATA_WIDTH-1]}}, bus.b, 1'b0};
      grp_idx <= '0;
    end else if (state == ST_RUN) begin
      if (bus.flush) begin
        grp_idx <= '0;
      end else if (advance) begin
        if (last_grp) begin
          grp_idx <= '0;
        end else begin
          sreg    <= sreg >> 3;
          grp_idx <= grp_idx + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.sel       = sel;
  assign bus.last      = last;
  assign bus.grp_idx   = grp_idx;

endmodule
